// File: rtl/dac_pkg.sv
// Shared types and default parameters for the DAC serialiser output stage.
//   ser_state_t : serialiser FSM states (IDLE, LOAD, SHIFT, GAP)
//   DEF_N       : default sample width
//   DEF_DEPTH   : default sample FIFO depth (power of two, >= 2)
//   DEF_CLK_DIV : default ck cycles per sclk half-period (>= 1)
package dac_pkg;

    localparam int DEF_N       = 16;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_CLK_DIV = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } ser_state_t;

endpackage

// File: rtl/dac_serialiser_if.sv
// Bus bundle between the fir filter / DAC pins and dac_serialiser.
//   sample_in, sample_valid : filtered sample and its strobe (into the serialiser)
//   sclk, cs_n, sdo         : SPI-style serial DAC frame (out of the serialiser)
//   busy, overflow          : status (out of the serialiser)
//   dbg_state               : current serialiser FSM state, for observation only
// Handshake: sample_valid is a one-cycle strobe with no back-pressure; the
// sample on sample_in must stay stable for the two cycles after the strobe.
// master = producer/observer side, slave = dac_serialiser side.
interface dac_serialiser_if #(
    parameter int N = 16
);
    import dac_pkg::*;

    logic [N-1:0] sample_in;
    logic         sample_valid;
    logic         sclk;
    logic         cs_n;
    logic         sdo;
    logic         busy;
    logic         overflow;
    ser_state_t   dbg_state;

    modport master (
        output sample_in, sample_valid,
        input  sclk, cs_n, sdo, busy, overflow, dbg_state
    );

    modport slave (
        input  sample_in, sample_valid,
        output sclk, cs_n, sdo, busy, overflow, dbg_state
    );

endinterface

// File: rtl/sample_fifo.sv
// Small circular sample FIFO.
//   ck, rst      : clock, synchronous active-high reset
//   push_i       : write wdata_i (ignored when full unless a pop happens on the same edge)
//   pop_i        : drop the head entry (ignored when empty)
//   wdata_i      : sample to write
//   rdata_o      : head entry (valid while !empty_o)
//   full_o       : count == DEPTH
//   empty_o      : count == 0
//   count_nxt_o  : occupancy after the current edge
module sample_fifo #(
    parameter int N     = 16,
    parameter int DEPTH = 4
) (
    input  logic                     ck,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [N-1:0]             wdata_i,
    output logic [N-1:0]             rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_nxt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [N-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO still succeeds if the head leaves on the same edge.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    assign count_nxt_o = count_d;

    always_ff @(posedge ck) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge ck) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/dac_serialiser.sv
// Output stage after the fir filter: captures each filtered sample, buffers it
// in sample_fifo and shifts it MSB-first to a serial DAC (cs_n, sclk, sdo).
//   ck, rst : clock, synchronous active-high reset (aborts any frame in flight)
//   bus     : dac_serialiser_if slave modport (sample_in/sample_valid in;
//             sclk, cs_n, sdo, busy, overflow, dbg_state out)
// Frame: cs_n low for 1 + 2*N*CLK_DIV cycles, sclk idles low, DAC samples sdo
// on sclk rising, sdo changes on sclk falling.
// Build option: DAC_OFFSET_BINARY_EN defined -> MSB inverted on load
// (two's complement to offset binary); undefined -> sample shifted unchanged.
module dac_serialiser
    import dac_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic             ck,
    input  logic             rst,
    dac_serialiser_if.slave  bus
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(N);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

    ser_state_t           state_q, state_d;
    logic [N-1:0]         shreg_q, shreg_d;
    logic [DW-1:0]        div_cnt_q, div_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 sclk_q, sclk_d;
    logic                 cs_n_q, cs_n_d;
    logic                 sdo_q, sdo_d;
    logic                 busy_q, busy_d;
    logic                 overflow_q, overflow_d;
    logic                 valid_d_q;
    logic                 pop;
    logic [N-1:0]         head;
    logic [N-1:0]         load_word;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [$clog2(DEPTH):0] count_nxt;

    // The fir output settles on the edge that ends its valid cycle, so the
    // sample is pushed one cycle after the strobe, using the delayed strobe.
    sample_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .ck          (ck),
        .rst         (rst),
        .push_i      (valid_d_q),
        .pop_i       (pop),
        .wdata_i     (bus.sample_in),
        .rdata_o     (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_nxt_o (count_nxt)
    );

`ifdef DAC_OFFSET_BINARY_EN
    assign load_word = {~head[N-1], head[N-2:0]};
`else
    assign load_word = head;
`endif

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        sdo_d     = sdo_q;
        pop       = 1'b0;

        case (state_q)
            IDLE: begin
                sclk_d = 1'b0;
                cs_n_d = 1'b1;
                if (!fifo_empty) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                pop       = 1'b1;
                shreg_d   = load_word;
                cs_n_d    = 1'b0;
                sdo_d     = load_word[N-1];
                div_cnt_d = '0;
                bit_cnt_d = '0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    sclk_d    = ~sclk_q;
                    if (sclk_q) begin
                        // Falling edge: present the next bit. Zeros shift in,
                        // so sdo returns low after the last bit.
                        shreg_d   = shreg_q << 1;
                        sdo_d     = shreg_q[N-2];
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_d = '0;
                            state_d   = GAP;
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DW'(1);
                end
            end
            GAP: begin
                // cs_n stays low through the first GAP cycle, giving the
                // extra cycle of chip-select hold after the last sclk fall.
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    div_cnt_d = div_cnt_q + DW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        overflow_d = overflow_q | (valid_d_q & fifo_full & ~pop);
        // busy is registered from next-state values so it equals
        // (state != IDLE) | (count != 0) | valid_d in the same cycle.
        busy_d = (state_d != IDLE) | (count_nxt != '0) | bus.sample_valid;
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            sclk_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            sdo_q      <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            valid_d_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            sdo_q      <= sdo_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
            valid_d_q  <= bus.sample_valid;
        end
    end

    assign bus.sclk      = sclk_q;
    assign bus.cs_n      = cs_n_q;
    assign bus.sdo       = sdo_q;
    assign bus.busy      = busy_q;
    assign bus.overflow  = overflow_q;
    assign bus.dbg_state = state_q;

endmodule
